// File: rtl/nvme_cq_pkg.sv
// Shared types and queue indices for the NVMe completion-queue monitor.
package nvme_cq_pkg;

    localparam logic [1:0] QID_ADM0 = 2'd0;
    localparam logic [1:0] QID_IO0  = 2'd1;
    localparam logic [1:0] QID_ADM1 = 2'd2;
    localparam logic [1:0] QID_IO1  = 2'd3;

    typedef struct packed {
        logic [1:0]  qid;
        logic [15:0] cid;
        logic [14:0] status;
        logic [15:0] sqhd;
    } cpl_rec_t;

endpackage

// File: rtl/nvme_cpl_fifo.sv
// Completion record FIFO: a ring buffer behind a registered output stage; DEPTH counts both.
module nvme_cpl_fifo
    import nvme_cq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     axi_aclk,
    input  logic     axi_aresetn,
    input  logic     push_valid,
    input  cpl_rec_t push_data,
    output logic     push_ready,
    output logic     out_valid,
    output cpl_rec_t out_data,
    input  logic     out_ready
);
    localparam int AW = $clog2(DEPTH);

    cpl_rec_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     ring_cnt_q, ring_cnt_d;
    logic            out_valid_q, out_valid_d;
    cpl_rec_t        out_data_q, out_data_d;
    logic            pop_s, full_s, push_ok_s, load_s, ring_rd_s, bypass_s, ring_wr_s;

    // The ring only fills while the output stage is occupied, so DEPTH-1 ring entries means full.
    always_comb begin
        pop_s      = out_valid_q && out_ready;
        full_s     = out_valid_q && (ring_cnt_q == (AW+1)'(DEPTH - 1));
        push_ok_s  = push_valid && (!full_s || pop_s);
        load_s     = !out_valid_q || pop_s;
        ring_rd_s  = load_s && (ring_cnt_q != '0);
        bypass_s   = load_s && (ring_cnt_q == '0) && push_ok_s;
        ring_wr_s  = push_ok_s && !bypass_s;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ring_rd_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            out_valid_d = 1'b1;
            out_data_d  = push_data;
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        wr_ptr_d   = ring_wr_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = ring_rd_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ring_cnt_d = ring_cnt_q + (AW+1)'(ring_wr_s) - (AW+1)'(ring_rd_s);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ring_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ring_cnt_q  <= ring_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (ring_wr_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign push_ready = !full_s || pop_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

endmodule

// File: rtl/nvme_cq_monitor.sv
// Snoops CQ entry writes into the Rx buffer, streams completion records and tracks head/phase.
// Define NVME_CQ_DOORBELL_EN to generate CQ-head doorbell requests (otherwise db_* tie to 0).
module nvme_cq_monitor
    import nvme_cq_pkg::*;
#(
    parameter int RX_ADDR_BITS = 10,
    parameter int ADM_CQ_NUM   = 4,
    parameter int IO_CQ_NUM    = 64,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    init_done,
    input  logic                    rx_write_valid,
    input  logic [3:0]              rx_write,
    input  logic [RX_ADDR_BITS-1:0] rx_waddr,
    input  logic [127:0]            rx_wdata,
    input  logic [3:0]              cq_reset,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [1:0]              cpl_qid,
    output logic [15:0]             cpl_cid,
    output logic [14:0]             cpl_status,
    output logic [15:0]             cpl_sqhd,
    output logic                    db_valid,
    input  logic                    db_ready,
    output logic [1:0]              db_qid,
    output logic [RX_ADDR_BITS-1:0] db_head,
    output logic                    err_seq,
    output logic                    err_ovf
);
    localparam logic [RX_ADDR_BITS-1:0] Q1_BASE = RX_ADDR_BITS'(ADM_CQ_NUM);
    localparam logic [RX_ADDR_BITS-1:0] Q2_BASE = RX_ADDR_BITS'(ADM_CQ_NUM + IO_CQ_NUM);
    localparam logic [RX_ADDR_BITS-1:0] Q3_BASE = RX_ADDR_BITS'(2 * ADM_CQ_NUM + IO_CQ_NUM);
    localparam logic [RX_ADDR_BITS-1:0] CQ_END  = RX_ADDR_BITS'(2 * (ADM_CQ_NUM + IO_CQ_NUM));

    function automatic logic [RX_ADDR_BITS-1:0] cq_last(input logic [1:0] qid);
        cq_last = (qid == QID_IO0 || qid == QID_IO1) ? RX_ADDR_BITS'(IO_CQ_NUM - 1)
                                                     : RX_ADDR_BITS'(ADM_CQ_NUM - 1);
    endfunction

    logic                    s1_valid_q, s1_valid_d, s1_full_q, s1_full_d, s1_phase_q, s1_phase_d;
    logic [RX_ADDR_BITS-1:0] s1_idx_q, s1_idx_d;
    logic [3:0]              s1_cq_reset_q, s1_cq_reset_d;
    cpl_rec_t                s1_rec_q, s1_rec_d;
    logic [RX_ADDR_BITS-1:0] head_q [4];
    logic [RX_ADDR_BITS-1:0] head_d [4];
    logic [3:0]              exp_phase_q, exp_phase_d;
    logic                    err_seq_q, err_seq_d, err_ovf_q, err_ovf_d;
    logic                    hit_s, match_s, accept_s, push_ready_s;
    logic [3:0]              acc_onehot_s;
    cpl_rec_t                out_rec_s;
    logic                    unused_s;

    // Stage 1: qualify the write and split the address into queue and queue-relative index.
    always_comb begin
        s1_valid_d    = init_done && rx_write_valid && (rx_waddr < CQ_END);
        s1_full_d     = (rx_write == 4'hf);
        s1_phase_d    = rx_wdata[112];
        s1_cq_reset_d = cq_reset;
        s1_rec_d      = '{qid: QID_ADM0, cid: rx_wdata[111:96], status: rx_wdata[127:113],
                          sqhd: rx_wdata[79:64]};
        if (rx_waddr < Q1_BASE) begin
            s1_rec_d.qid = QID_ADM0;
            s1_idx_d     = rx_waddr;
        end else if (rx_waddr < Q2_BASE) begin
            s1_rec_d.qid = QID_IO0;
            s1_idx_d     = rx_waddr - Q1_BASE;
        end else if (rx_waddr < Q3_BASE) begin
            s1_rec_d.qid = QID_ADM1;
            s1_idx_d     = rx_waddr - Q2_BASE;
        end else begin
            s1_rec_d.qid = QID_IO1;
            s1_idx_d     = rx_waddr - Q3_BASE;
        end
    end

    // Stage 2: compare against live head/phase; a queue reset in the same slot drops the entry silently.
    always_comb begin
        hit_s        = s1_valid_q && !s1_cq_reset_q[s1_rec_q.qid];
        match_s      = s1_full_q && (s1_idx_q == head_q[s1_rec_q.qid])
                       && (s1_phase_q == exp_phase_q[s1_rec_q.qid]);
        accept_s     = hit_s && match_s;
        acc_onehot_s = accept_s ? (4'b0001 << s1_rec_q.qid) : 4'b0000;
        err_seq_d    = err_seq_q | (hit_s && !match_s);
        err_ovf_d    = err_ovf_q | (accept_s && !push_ready_s);
        head_d       = head_q;
        exp_phase_d  = exp_phase_q;
        for (int q = 0; q < 4; q++) begin
            if (s1_cq_reset_q[q]) begin
                head_d[q]      = '0;
                exp_phase_d[q] = 1'b1;
            end else if (acc_onehot_s[q] && head_q[q] == cq_last(2'(q))) begin
                head_d[q]      = '0;
                exp_phase_d[q] = ~exp_phase_q[q];
            end else if (acc_onehot_s[q]) begin
                head_d[q]      = head_q[q] + RX_ADDR_BITS'(1);
            end else begin
                head_d[q]      = head_q[q];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            s1_valid_q    <= 1'b0;
            s1_full_q     <= 1'b0;
            s1_phase_q    <= 1'b0;
            s1_idx_q      <= '0;
            s1_cq_reset_q <= 4'b0000;
            s1_rec_q      <= '0;
            exp_phase_q   <= 4'b1111;
            err_seq_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
            for (int q = 0; q < 4; q++) head_q[q] <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_full_q     <= s1_full_d;
            s1_phase_q    <= s1_phase_d;
            s1_idx_q      <= s1_idx_d;
            s1_cq_reset_q <= s1_cq_reset_d;
            s1_rec_q      <= s1_rec_d;
            exp_phase_q   <= exp_phase_d;
            err_seq_q     <= err_seq_d;
            err_ovf_q     <= err_ovf_d;
            head_q        <= head_d;
        end
    end

    nvme_cpl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .push_valid  (accept_s),
        .push_data   (s1_rec_q),
        .push_ready  (push_ready_s),
        .out_valid   (cpl_valid),
        .out_data    (out_rec_s),
        .out_ready   (cpl_ready)
    );

    assign cpl_qid    = out_rec_s.qid;
    assign cpl_cid    = out_rec_s.cid;
    assign cpl_status = out_rec_s.status;
    assign cpl_sqhd   = out_rec_s.sqhd;
    assign err_seq    = err_seq_q;
    assign err_ovf    = err_ovf_q;
    assign unused_s   = ^{rx_wdata[95:80], rx_wdata[63:0]};

`ifdef NVME_CQ_DOORBELL_EN
    logic [3:0]              pending_q, pending_d;
    logic [1:0]              last_q, last_d, db_qid_q, db_qid_d, cand_s, grant_qid_s;
    logic                    db_valid_q, db_valid_d, db_stale_q, db_stale_d;
    logic [RX_ADDR_BITS-1:0] db_head_q, db_head_d;
    logic                    grant_s, issue_s, hs_s;

    // Round-robin from the queue after the last grant; stale marks a head move while a request is in flight.
    always_comb begin
        grant_s     = 1'b0;
        grant_qid_s = last_q;
        cand_s      = last_q;
        for (int i = 4; i >= 1; i--) begin
            cand_s      = last_q + 2'(i);
            grant_qid_s = pending_q[cand_s] ? cand_s : grant_qid_s;
            grant_s     = grant_s | pending_q[cand_s];
        end
        issue_s    = !db_valid_q && grant_s;
        hs_s       = db_valid_q && db_ready;
        db_valid_d = issue_s ? 1'b1 : (hs_s ? 1'b0 : db_valid_q);
        db_qid_d   = issue_s ? grant_qid_s : db_qid_q;
        db_head_d  = issue_s ? head_q[grant_qid_s] : db_head_q;
        last_d     = issue_s ? grant_qid_s : last_q;
        db_stale_d = issue_s ? 1'b0 : (db_stale_q | (db_valid_q && acc_onehot_s[db_qid_q]));
        pending_d  = pending_q;
        for (int q = 0; q < 4; q++) begin
            if (s1_cq_reset_q[q]) begin
                pending_d[q] = 1'b0;
            end else if (acc_onehot_s[q]) begin
                pending_d[q] = 1'b1;
            end else if (hs_s && db_qid_q == 2'(q) && !db_stale_q) begin
                pending_d[q] = 1'b0;
            end else begin
                pending_d[q] = pending_q[q];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pending_q  <= 4'b0000;
            last_q     <= QID_IO1;
            db_valid_q <= 1'b0;
            db_qid_q   <= 2'd0;
            db_head_q  <= '0;
            db_stale_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            last_q     <= last_d;
            db_valid_q <= db_valid_d;
            db_qid_q   <= db_qid_d;
            db_head_q  <= db_head_d;
            db_stale_q <= db_stale_d;
        end
    end

    assign db_valid = db_valid_q;
    assign db_qid   = db_qid_q;
    assign db_head  = db_head_q;
`else
    logic unused_db_s;
    assign unused_db_s = db_ready ^ (^acc_onehot_s);
    assign db_valid    = 1'b0;
    assign db_qid      = 2'd0;
    assign db_head     = '0;
`endif

endmodule

// File: tb/tb_nvme_cq_monitor.sv
// Self-checking bench for nvme_cq_monitor: vector table plus hand-written multi-cycle sequences.
module tb_nvme_cq_monitor;
    localparam int AB = 10;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn, init_done, rx_write_valid, cpl_valid, cpl_ready;
    logic          db_valid, db_ready, err_seq, err_ovf;
    logic [3:0]    rx_write, cq_reset;
    logic [AB-1:0] rx_waddr, db_head;
    logic [127:0]  rx_wdata;
    logic [1:0]    cpl_qid, db_qid;
    logic [15:0]   cpl_cid, cpl_sqhd;
    logic [14:0]   cpl_status;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  qid;
        logic [15:0] cid;
        logic [14:0] status;
        logic [15:0] sqhd;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic          init;
        logic [AB-1:0] addr;
        logic          ph;
        logic [3:0]    mask;
        logic [1:0]    qid;
        logic          acc;
        logic          err;
    } vec_t;
    vec_t tv[12];

    nvme_cq_monitor dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .init_done(init_done),
        .rx_write_valid(rx_write_valid), .rx_write(rx_write), .rx_waddr(rx_waddr),
        .rx_wdata(rx_wdata), .cq_reset(cq_reset),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_qid(cpl_qid), .cpl_cid(cpl_cid),
        .cpl_status(cpl_status), .cpl_sqhd(cpl_sqhd),
        .db_valid(db_valid), .db_ready(db_ready), .db_qid(db_qid), .db_head(db_head),
        .err_seq(err_seq), .err_ovf(err_ovf)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic idle();
        rx_write_valid = 1'b0;
        rx_write       = 4'h0;
        cq_reset       = 4'h0;
    endtask

    // One entry write for one cycle; the expected record is queued when an accept is predicted.
    task automatic drive(input logic [AB-1:0] a, input logic ph, input logic [15:0] cid,
                         input logic [3:0] mask, input logic exp_acc, input logic [1:0] qid);
        logic [14:0] st;
        logic [15:0] sq;
        exp_t        e;
        st = cid[14:0] ^ 15'h2a5a;
        sq = ~cid;
        rx_write_valid = 1'b1;
        rx_waddr       = a;
        rx_write       = mask;
        rx_wdata       = {st, ph, cid, 16'hbeef, sq, 64'ha5a5_5a5a_0123_4567};
        if (exp_acc) begin
            e = '{qid, cid, st, sq};
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic do_reset();
        idle();
        axi_aresetn = 1'b0;
        repeat (2) tick();
        sb.delete();
        axi_aresetn = 1'b1;
        tick();
    endtask

    // Scoreboard side: every handshaken record is popped and compared.
    always @(negedge axi_aclk) begin
        if (axi_aresetn && cpl_valid && cpl_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cpl: got qid=%0d cid=0x%0h, expected no record", cpl_qid, cpl_cid);
            end else begin
                mon_e = sb.pop_front();
                chk("cpl_qid", 64'(cpl_qid), 64'(mon_e.qid));
                chk("cpl_cid", 64'(cpl_cid), 64'(mon_e.cid));
                chk("cpl_status", 64'(cpl_status), 64'(mon_e.status));
                chk("cpl_sqhd", 64'(cpl_sqhd), 64'(mon_e.sqhd));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        axi_aresetn = 1'b0; init_done = 1'b0; rx_waddr = '0; rx_wdata = '0;
        cpl_ready = 1'b1; db_ready = 1'b1;
        idle();
        repeat (3) tick();
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        chk("rst_cpl_qid", 64'(cpl_qid), 64'd0);
        chk("rst_cpl_cid", 64'(cpl_cid), 64'd0);
        chk("rst_cpl_status", 64'(cpl_status), 64'd0);
        chk("rst_cpl_sqhd", 64'(cpl_sqhd), 64'd0);
        chk("rst_db_valid", 64'(db_valid), 64'd0);
        chk("rst_db_qid", 64'(db_qid), 64'd0);
        chk("rst_db_head", 64'(db_head), 64'd0);
        chk("rst_err_seq", 64'(err_seq), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);

        // Latency: q1 idx0 write in cycle N, record at N+2, doorbell at N+3.
        init_done = 1'b1;
        tick();
        drive(10'd4, 1'b1, 16'h0012, 4'hf, 1'b1, 2'd1);
        idle();
        @(negedge axi_aclk);
        chk("lat_n1_cpl_valid", 64'(cpl_valid), 64'd0);
        tick();
        @(negedge axi_aclk);
        chk("lat_n2_cpl_valid", 64'(cpl_valid), 64'd1);
        chk("lat_n2_db_valid", 64'(db_valid), 64'd0);
        tick();
        @(negedge axi_aclk);
`ifdef NVME_CQ_DOORBELL_EN
        chk("lat_n3_db_valid", 64'(db_valid), 64'd1);
        chk("lat_n3_db_qid", 64'(db_qid), 64'd1);
        chk("lat_n3_db_head", 64'(db_head), 64'd1);
`else
        chk("lat_n3_db_valid_off", 64'(db_valid), 64'd0);
        chk("lat_n3_db_head_off", 64'(db_head), 64'd0);
`endif

        // Vector table from a fresh reset: heads 0, phases 1.
        do_reset();
        tv[0]  = '{1'b0, 10'd0,   1'b1, 4'hf, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 10'd0,   1'b1, 4'hf, 2'd0, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 10'd4,   1'b1, 4'hf, 2'd1, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 10'd68,  1'b1, 4'hf, 2'd2, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 10'd72,  1'b1, 4'hf, 2'd3, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 10'd1,   1'b1, 4'hf, 2'd0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 10'd200, 1'b1, 4'hf, 2'd0, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 10'd136, 1'b1, 4'hf, 2'd0, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 10'd73,  1'b1, 4'hf, 2'd3, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 10'd5,   1'b1, 4'h7, 2'd1, 1'b0, 1'b1};
        tv[10] = '{1'b1, 10'd5,   1'b1, 4'hf, 2'd1, 1'b1, 1'b1};
        tv[11] = '{1'b1, 10'd2,   1'b0, 4'hf, 2'd0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            init_done = tv[i].init;
            drive(tv[i].addr, tv[i].ph, 16'h1000 + 16'(i), tv[i].mask, tv[i].acc, tv[i].qid);
            idle();
            init_done = 1'b1;
            repeat (2) tick();
            @(negedge axi_aclk);
            chk($sformatf("vec%0d_err_seq", i), 64'(err_seq), 64'(tv[i].err));
        end

        // q0 wrap: four back-to-back accepts, then a stale-phase write must be rejected.
        do_reset();
        for (int i = 0; i < 4; i++) drive(10'(i), 1'b1, 16'h3000 + 16'(i), 4'hf, 1'b1, 2'd0);
        idle();
        repeat (2) tick();
        @(negedge axi_aclk);
        chk("wrap_err_seq_clean", 64'(err_seq), 64'd0);
        tick();
        drive(10'd0, 1'b1, 16'h3004, 4'hf, 1'b0, 2'd0);
        idle();
        repeat (2) tick();
        @(negedge axi_aclk);
        chk("wrap_stale_phase_err", 64'(err_seq), 64'd1);
        tick();
        drive(10'd0, 1'b0, 16'h3005, 4'hf, 1'b1, 2'd0);
        idle();
        repeat (3) tick();

        // Overflow: 17 back-to-back q1 entries with the sink stalled.
        do_reset();
        cpl_ready = 1'b0;
        for (int i = 0; i < 17; i++) drive(10'(4 + i), 1'b1, 16'h2000 + 16'(i), 4'hf, (i < 16), 2'd1);
        idle();
        repeat (3) tick();
        @(negedge axi_aclk);
        chk("ovf_err_ovf", 64'(err_ovf), 64'd1);
        chk("ovf_err_seq", 64'(err_seq), 64'd0);
        chk("ovf_hold_valid", 64'(cpl_valid), 64'd1);
        chk("ovf_hold_cid_a", 64'(cpl_cid), 64'h2000);
        repeat (3) tick();
        @(negedge axi_aclk);
        chk("ovf_hold_cid_b", 64'(cpl_cid), 64'h2000);
        tick();
        cpl_ready = 1'b1;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        chk("ovf_drain_left", 64'(sb.size()), 64'd0);
        drive(10'd21, 1'b1, 16'h2011, 4'hf, 1'b1, 2'd1);
        idle();
        repeat (3) tick();
        @(negedge axi_aclk);
        chk("ovf_head17_err_seq", 64'(err_seq), 64'd0);

        // cq_reset coinciding with a q2 write drops it silently; a later reset rewinds head.
        do_reset();
        cq_reset = 4'b0100;
        drive(10'd68, 1'b1, 16'h4000, 4'hf, 1'b0, 2'd2);
        idle();
        repeat (2) tick();
        @(negedge axi_aclk);
        chk("cqrst_same_cycle_err", 64'(err_seq), 64'd0);
        tick();
        drive(10'd68, 1'b1, 16'h4001, 4'hf, 1'b1, 2'd2);
        drive(10'd69, 1'b1, 16'h4002, 4'hf, 1'b1, 2'd2);
        idle();
        tick();
        cq_reset = 4'b0100;
        tick();
        cq_reset = 4'b0000;
        tick();
        drive(10'd68, 1'b1, 16'h4003, 4'hf, 1'b1, 2'd2);
        idle();
        repeat (3) tick();
        @(negedge axi_aclk);
        chk("cqrst_rewind_err", 64'(err_seq), 64'd0);

        // Doorbells: all four queues pending while the host stalls.
        do_reset();
        db_ready = 1'b0;
        drive(10'd0,  1'b1, 16'h5000, 4'hf, 1'b1, 2'd0);
        drive(10'd4,  1'b1, 16'h5001, 4'hf, 1'b1, 2'd1);
        drive(10'd68, 1'b1, 16'h5002, 4'hf, 1'b1, 2'd2);
        drive(10'd72, 1'b1, 16'h5003, 4'hf, 1'b1, 2'd3);
        idle();
        repeat (4) tick();
        @(negedge axi_aclk);
`ifdef NVME_CQ_DOORBELL_EN
        chk("db_stall_valid_a", 64'(db_valid), 64'd1);
        chk("db_stall_qid_a", 64'(db_qid), 64'd0);
        repeat (3) tick();
        @(negedge axi_aclk);
        chk("db_stall_valid_b", 64'(db_valid), 64'd1);
        chk("db_stall_qid_b", 64'(db_qid), 64'd0);
        chk("db_stall_head_b", 64'(db_head), 64'd1);
        tick();
        db_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            @(negedge axi_aclk);
            while (!db_valid && w < 20) begin
                @(negedge axi_aclk);
                w++;
            end
            chk($sformatf("db_grant%0d_seen", k), 64'(db_valid), 64'd1);
            chk($sformatf("db_grant%0d_qid", k), 64'(db_qid), 64'(k));
            chk($sformatf("db_grant%0d_head", k), 64'(db_head), 64'd1);
        end
        repeat (4) tick();
        @(negedge axi_aclk);
        chk("db_idle_after_grants", 64'(db_valid), 64'd0);
`else
        chk("db_off_valid", 64'(db_valid), 64'd0);
        chk("db_off_qid", 64'(db_qid), 64'd0);
        chk("db_off_head", 64'(db_head), 64'd0);
`endif
        db_ready = 1'b1;

        repeat (5) tick();
        chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nvme_cq_monitor.md
# nvme_cq_monitor

Snoops the completion-queue writes that the NVMe PCIe slave commits into the Rx buffer and turns each valid completion entry into a record on a ready/valid stream. It tracks per-queue CQ head and expected phase for the four completion queues (SSD0 admin/IO, SSD1 admin/IO) and issues CQ-head doorbell requests toward the NVMe host controller. It sits directly downstream of the PCIe slave's Rx buffer write port, in parallel with the Rx buffer RAM.

## Interface
- RX_ADDR_BITS, 10: Rx buffer word address width; one 128-bit word is one CQ entry.
- ADM_CQ_NUM, 4: entries per admin CQ.
- IO_CQ_NUM, 64: entries per IO CQ.
- FIFO_DEPTH, 16: completion record FIFO depth (power of two).

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset; asynchronous, active-low.
- init_done  in  1  Rx buffer zeroing finished; snoop ignored while low.
- rx_write_valid  in  1  full-entry write strobe from slave.
- rx_write  in  4  per-dword write enables.
- rx_waddr  in  RX_ADDR_BITS  Rx word address.
- rx_wdata  in  128  entry data.
- cq_reset  in  4  one pulse per queue (bit q): reinitialise head/phase of queue q.
- cpl_valid  out  1; cpl_ready  in  1  completion record handshake.
- cpl_qid  out  2; cpl_cid  out  16; cpl_status  out  15; cpl_sqhd  out  16.
- db_valid  out  1; db_ready  in  1  doorbell request handshake.
- db_qid  out  2; db_head  out  RX_ADDR_BITS  new CQ head to write.
- err_seq  out  1  sticky: index/phase mismatch or partial write.
- err_ovf  out  1  sticky: record dropped, FIFO full.

## Operation
- Queue bases: q0=0, q1=ADM, q2=ADM+IO, q3=2·ADM+IO; addresses ≥ 2·(ADM+IO) are data region, ignored.
- Entry fields: sqhd=wdata[79:64], cid=wdata[111:96], phase=wdata[112], status=wdata[127:113].
- Per queue: head (0 after reset), exp_phase (1 after reset); depth D = ADM_CQ_NUM for q0/q2, IO_CQ_NUM for q1/q3.
- Snoop (init_done=1, rx_write_valid=1, CQ region):
  - Accept when rx_write==4'hf, idx==head[q] and phase==exp_phase[q].
  - On accept: push record; head ← head+1; at head==D−1, wrap to 0 and toggle exp_phase; set pending[q].
  - Partial mask or mismatch: set err_seq; no push, head unchanged.
- FIFO full on accept: record dropped and err_ovf set; head still advances and pending is still set.
- Doorbell (macro enabled): round-robin over pending[3:0] starting after the last granted queue. db_head is sampled as head[q] at issue, with cq_base[q] excluded (queue-relative). Pending clears on db_valid&&db_ready. Accepts arriving while a request is outstanding re-set pending, so coalescing is permitted.
- cq_reset[q]: head←0, exp_phase←1, pending[q]←0. Wins over a simultaneous accept to q; that entry is dropped silently. An outstanding db request for q is not retracted.
- Sticky errors clear only on reset.

## Timing
- Reset values: cpl_valid=0, db_valid=0, all payload outputs 0, err_seq=0, err_ovf=0.
- Stage 1 registers snoop inputs and decodes them; stage 2 compares, updates state and pushes the record.
- rx_write_valid in cycle N → cpl_valid earliest N+2 (FIFO registered output); pending set at N+2, db_valid earliest N+3.
- Back-to-back accepts, one per cycle, are sustained, including consecutive accepts to the same queue (head forwarded).
- cpl_* and db_* hold stable while valid && !ready.
- Simultaneous FIFO push and pop when full: the pop frees a slot, so the push succeeds.

## Configuration
- NVME_CQ_DOORBELL_EN defined: pending/arbiter logic present; db_* driven as above.
- Not defined: db_valid, db_qid and db_head tied to 0, db_ready ignored, no pending state. Host software rings the doorbells.

## Structure
- Package nvme_cq_pkg holds cpl_rec_t {qid, cid, status, sqhd} and the queue index constants.
- Sub-module nvme_cpl_fifo: synchronous FIFO of cpl_rec_t with registered output.

## Test plan
- Write q1 idx0 (addr 4), phase=1, cid=0x0012 → cpl at N+2 with qid=1, cid=0x0012; db_head=1 for q1.
- Four q0 writes idx0..3, phase 1 → head wraps to 0 and exp_phase=0; a fifth write with phase 1 → err_seq=1, no record.
- Hold cpl_ready=0, push 17 entries → 16 records, err_ovf=1; then heads equal 17 mod D.
- Pending q0..q3 together, db_ready=1 → grants in order 0,1,2,3; db_ready=0 holds db_* stable.
- cq_reset[2] in the same cycle as a valid q2 write → no record; head[2]=0.
- rx_write=4'h7 with valid, and writes before init_done → err_seq=1 only for the former; no records.
